hit_detector: RTL

HIT_DETECTOR -- requirements
Module: hit_detector

---
 rtl/hit_detector_if.sv | 28 ++
 rtl/hit_detector.sv | 112 +++++++++++
 2 files changed

// File: rtl/hit_detector_if.sv
// rtl/hit_detector_if.sv - pixel stream, trigger and result signals of the hit detector
interface hit_detector_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       frame_start;
  logic       frame_done;
  logic       fire;
  logic       reload;
  logic [7:0] aim_x;
  logic [6:0] aim_y;
  logic       hit;
  logic       miss;
  logic       busy;
  logic [7:0] hit_count;
  logic [3:0] shots;

  modport master (
    output plot, x, y, colour, frame_start, frame_done, fire, reload, aim_x, aim_y,
    input  hit, miss, busy, hit_count, shots
  );

  modport slave (
    input  plot, x, y, colour, frame_start, frame_done, fire, reload, aim_x, aim_y,
    output hit, miss, busy, hit_count, shots
  );
endinterface

// File: rtl/hit_detector.sv
// rtl/hit_detector.sv - scores a shot by watching the next draw pass for a non-background
// pixel inside the crosshair window
module hit_detector #(
  parameter int         WINDOW    = 1,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         AMMO      = 3
) (
  input logic           clock,
  input logic           resetn,
  hit_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} state_t;

  localparam logic [8:0] WIN_X  = 9'(WINDOW);
  localparam logic [7:0] WIN_Y  = 8'(WINDOW);
  localparam logic [3:0] AMMO_L = 4'(AMMO);

  state_t     r_state;
  logic       r_fire_q;
  logic [7:0] r_cap_x;
  logic [6:0] r_cap_y;
  logic       r_found;
  logic       r_hit;
  logic       r_miss;
  logic       r_busy;
  logic [7:0] r_hit_count;
  logic [3:0] r_shots;

  logic [8:0] w_dx;
  logic [8:0] w_adx;
  logic [7:0] w_dy;
  logic [7:0] w_ady;
  logic       w_match;
  logic       w_found_next;
  logic       w_fire_edge;

  // Zero-extended differences keep the sign bit, so screen edges never wrap around.
  assign w_dx  = {1'b0, bus.x} - {1'b0, r_cap_x};
  assign w_adx = w_dx[8] ? (~w_dx + 9'd1) : w_dx;
  assign w_dy  = {1'b0, bus.y} - {1'b0, r_cap_y};
  assign w_ady = w_dy[7] ? (~w_dy + 8'd1) : w_dy;

  assign w_match      = bus.plot && (bus.colour != BG_COLOUR) && (w_adx <= WIN_X) && (w_ady <= WIN_Y);
  assign w_found_next = r_found | w_match;
  assign w_fire_edge  = bus.fire & ~r_fire_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_fire_q    <= 1'b1;
      r_cap_x     <= '0;
      r_cap_y     <= '0;
      r_found     <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_busy      <= 1'b0;
      r_hit_count <= '0;
      r_shots     <= AMMO_L;
    end else begin
      r_fire_q <= bus.fire;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fire_edge && (r_shots != 4'd0)) begin
            r_cap_x <= bus.aim_x;
            r_cap_y <= bus.aim_y;
            r_shots <= r_shots - 4'd1;
            r_busy  <= 1'b1;
            r_state <= ARMED;
          end else if (bus.reload) begin
            r_shots <= AMMO_L;
          end
        end
        ARMED: begin
          if (bus.frame_start) begin
            r_found <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_found <= w_found_next;
          // The closing pixel still counts, so the result uses the updated flag.
          if (bus.frame_done) begin
            r_hit   <= w_found_next;
            r_miss  <= ~w_found_next;
            r_state <= REPORT;
            if (w_found_next && (r_hit_count != 8'hFF)) begin
              r_hit_count <= r_hit_count + 8'd1;
            end
          end
        end
        REPORT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.hit       = r_hit;
  assign bus.miss      = r_miss;
  assign bus.busy      = r_busy;
  assign bus.hit_count = r_hit_count;
  assign bus.shots     = r_shots;

endmodule
